chain_code_shape_analyzer: RTL and testbench

- Downstream consumer of the border-tracing encoder stage. Accepts the start point and a stream of 3-bit Freeman chain codes, one per strobe, on a 64x64 binary image.
- Reconstructs the contour position on the fly and produces shape descriptors when the chain ends:
  - bounding box
  - step count
  - even/odd code counts (for corrected perimeter)
  - signed doubled polygon area (shoelace)
  - closure check
- Results are held until the next start; a host or display stage reads them.

---
 rtl/shape_pkg.sv | 46 ++++
 rtl/chain_code_shape_analyzer_if.sv | 43 ++++
 rtl/chain_code_step_decoder.sv | 19 +
 rtl/chain_code_shape_analyzer.sv | 175 +++++++++++++++++
 tb/tb_chain_code_shape_analyzer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/shape_pkg.sv
// Shared definitions for the chain-code stages: default widths, FSM encoding
// and the Freeman code to (dx,dy) direction table.
package shape_pkg;

  localparam int COORD_W_DEF = 6;
  localparam int STEP_W_DEF  = 8;
  localparam int AREA_W_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } step_t;

  // Row index grows downward, so "up" in the image is dy = -1.
  localparam step_t DIR_0 = {2'b01, 2'b00};
  localparam step_t DIR_1 = {2'b01, 2'b11};
  localparam step_t DIR_2 = {2'b00, 2'b11};
  localparam step_t DIR_3 = {2'b11, 2'b11};
  localparam step_t DIR_4 = {2'b11, 2'b00};
  localparam step_t DIR_5 = {2'b11, 2'b01};
  localparam step_t DIR_6 = {2'b00, 2'b01};
  localparam step_t DIR_7 = {2'b01, 2'b01};

  function automatic step_t dir_of(input logic [2:0] code);
    step_t s;
    unique case (code)
      3'd0: s = DIR_0;
      3'd1: s = DIR_1;
      3'd2: s = DIR_2;
      3'd3: s = DIR_3;
      3'd4: s = DIR_4;
      3'd5: s = DIR_5;
      3'd6: s = DIR_6;
      3'd7: s = DIR_7;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/chain_code_shape_analyzer_if.sv
// Chain input strobes and shape-descriptor results between the encoder/host
// side (master) and the analyzer (slave).
interface chain_code_shape_analyzer_if
  import shape_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int STEP_W  = STEP_W_DEF,
  parameter int AREA_W  = AREA_W_DEF
) ();

  logic               start_valid;
  logic [COORD_W-1:0] start_x;
  logic [COORD_W-1:0] start_y;
  logic               code_valid;
  logic [2:0]         code_in;
  logic               chain_end;

  logic               busy;
  logic [COORD_W-1:0] min_x;
  logic [COORD_W-1:0] max_x;
  logic [COORD_W-1:0] min_y;
  logic [COORD_W-1:0] max_y;
  logic [STEP_W-1:0]  step_count;
  logic [STEP_W-1:0]  even_count;
  logic [STEP_W-1:0]  odd_count;
  logic [AREA_W-1:0]  area2;
  logic               closed;
  logic               result_valid;
  logic               error;

  modport master (
    output start_valid, start_x, start_y, code_valid, code_in, chain_end,
    input  busy, min_x, max_x, min_y, max_y, step_count, even_count,
           odd_count, area2, closed, result_valid, error
  );

  modport slave (
    input  start_valid, start_x, start_y, code_valid, code_in, chain_end,
    output busy, min_x, max_x, min_y, max_y, step_count, even_count,
           odd_count, area2, closed, result_valid, error
  );

endinterface

// File: rtl/chain_code_step_decoder.sv
// Combinational Freeman code decoder: unit step (dx,dy) and diagonal flag.
module chain_code_step_decoder
  import shape_pkg::*;
(
  input  logic              code_in_i,
  input  logic [2:0]        code_i,
  output logic signed [1:0] dx,
  output logic signed [1:0] dy,
  output logic              is_diagonal
);

  step_t step;

  assign step        = dir_of(code_i);
  assign dx          = step.dx;
  assign dy          = step.dy;
  assign is_diagonal = code_i[0] & code_in_i;

endmodule

// File: rtl/chain_code_shape_analyzer.sv
// Tracks the contour position from a chain-code stream and accumulates the
// bounding box, step statistics and doubled shoelace area for one chain.
module chain_code_shape_analyzer
  import shape_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int STEP_W  = STEP_W_DEF,
  parameter int AREA_W  = AREA_W_DEF
) (
  input logic Clk,
  input logic reset_n,
  chain_code_shape_analyzer_if.slave bus
);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [STEP_W-1:0]  step_q, step_d, even_q, even_d, odd_q, odd_d;
  logic [AREA_W-1:0]  area2_q, area2_d;
  logic               closed_q, closed_d, rv_q, rv_d, error_q, error_d;

  logic signed [1:0]  dx, dy;
  logic               is_diag;
  logic [COORD_W+1:0] nx_wide, ny_wide;
  logic [COORD_W-1:0] nx, ny, end_x, end_y;
  logic signed [AREA_W:0] x_ext, y_ext, term_x, term_y, term, area_sum;
  logic               wrap, step_full, area_ovf, fault;

  chain_code_step_decoder u_dec (
    .code_in_i   (1'b1),
    .code_i      (bus.code_in),
    .dx          (dx),
    .dy          (dy),
    .is_diagonal (is_diag)
  );

  // Two extra bits expose a step off either edge of the image as nonzero MSBs.
  assign nx_wide = {2'b00, cur_x_q} + {{COORD_W{dx[1]}}, dx};
  assign ny_wide = {2'b00, cur_y_q} + {{COORD_W{dy[1]}}, dy};
  assign nx      = nx_wide[COORD_W-1:0];
  assign ny      = ny_wide[COORD_W-1:0];
  assign wrap    = (nx_wide[COORD_W+1:COORD_W] != 2'b00) ||
                   (ny_wide[COORD_W+1:COORD_W] != 2'b00);

  // Shoelace term x*dy - y*dx with unit steps reduces to add/subtract/skip.
  assign x_ext    = $signed({{(AREA_W+1-COORD_W){1'b0}}, cur_x_q});
  assign y_ext    = $signed({{(AREA_W+1-COORD_W){1'b0}}, cur_y_q});
  assign term_x   = (dy == 2'sb01) ? x_ext : (dy == 2'sb11) ? -x_ext : '0;
  assign term_y   = (dx == 2'sb01) ? y_ext : (dx == 2'sb11) ? -y_ext : '0;
  assign term     = term_x - term_y;
  assign area_sum = $signed({area2_q[AREA_W-1], area2_q}) + term;
  assign area_ovf = area_sum[AREA_W] != area_sum[AREA_W-1];

  assign step_full = &step_q;
  assign fault     = bus.code_valid && (wrap || step_full || area_ovf);
  assign end_x     = bus.code_valid ? nx : cur_x_q;
  assign end_y     = bus.code_valid ? ny : cur_y_q;

  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    min_x_d   = min_x_q;
    max_x_d   = max_x_q;
    min_y_d   = min_y_q;
    max_y_d   = max_y_q;
    step_d    = step_q;
    even_d    = even_q;
    odd_d     = odd_q;
    area2_d   = area2_q;
    closed_d  = closed_q;
    rv_d      = rv_q;
    error_d   = error_q;

    if (bus.start_valid) begin
      state_d   = TRACE;
      cur_x_d   = bus.start_x;
      cur_y_d   = bus.start_y;
      start_x_d = bus.start_x;
      start_y_d = bus.start_y;
      min_x_d   = bus.start_x;
      max_x_d   = bus.start_x;
      min_y_d   = bus.start_y;
      max_y_d   = bus.start_y;
      step_d    = '0;
      even_d    = '0;
      odd_d     = '0;
      area2_d   = '0;
      closed_d  = 1'b0;
      rv_d      = 1'b0;
      error_d   = 1'b0;
    end else if (state_q == TRACE) begin
      if (fault) begin
        state_d = ERR;
        error_d = 1'b1;
        rv_d    = 1'b0;
      end else begin
        if (bus.code_valid) begin
          cur_x_d = nx;
          cur_y_d = ny;
          if (nx < min_x_q) min_x_d = nx;
          if (nx > max_x_q) max_x_d = nx;
          if (ny < min_y_q) min_y_d = ny;
          if (ny > max_y_q) max_y_d = ny;
          step_d  = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
          area2_d = area_sum[AREA_W-1:0];
          if (is_diag) odd_d  = odd_q + {{(STEP_W-1){1'b0}}, 1'b1};
          else         even_d = even_q + {{(STEP_W-1){1'b0}}, 1'b1};
        end
        if (bus.chain_end) begin
          state_d  = DONE;
          closed_d = (end_x == start_x_q) && (end_y == start_y_q);
          rv_d     = closed_d;
          error_d  = !closed_d;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      start_x_q <= '0;
      start_y_q <= '0;
      min_x_q   <= '1;
      max_x_q   <= '0;
      min_y_q   <= '1;
      max_y_q   <= '0;
      step_q    <= '0;
      even_q    <= '0;
      odd_q     <= '0;
      area2_q   <= '0;
      closed_q  <= 1'b0;
      rv_q      <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      start_x_q <= start_x_d;
      start_y_q <= start_y_d;
      min_x_q   <= min_x_d;
      max_x_q   <= max_x_d;
      min_y_q   <= min_y_d;
      max_y_q   <= max_y_d;
      step_q    <= step_d;
      even_q    <= even_d;
      odd_q     <= odd_d;
      area2_q   <= area2_d;
      closed_q  <= closed_d;
      rv_q      <= rv_d;
      error_q   <= error_d;
    end
  end

  assign bus.busy         = (state_q == TRACE);
  assign bus.min_x        = min_x_q;
  assign bus.max_x        = max_x_q;
  assign bus.min_y        = min_y_q;
  assign bus.max_y        = max_y_q;
  assign bus.step_count   = step_q;
  assign bus.even_count   = even_q;
  assign bus.odd_count    = odd_q;
  assign bus.area2        = area2_q;
  assign bus.closed       = closed_q;
  assign bus.result_valid = rv_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_chain_code_shape_analyzer.sv
// Randomized and directed bench for chain_code_shape_analyzer against a
// coordinate-level behavioural model of the chain.
module tb_chain_code_shape_analyzer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  chain_code_shape_analyzer_if bus ();

  chain_code_shape_analyzer dut (
    .Clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Freeman directions, row index increasing downward.
  int dxt [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int dyt [8] = '{0, -1, -1, -1, 0, 1, 1, 1};

  // Model state: 0 idle, 1 tracing, 2 done, 3 error.
  int m_state, mx, my, msx, msy, mminx, mmaxx, mminy, mmaxy;
  int mstep, meven, modd, marea, mclosed, mrv, merr;
  int t_dx, t_dy, t_nx, t_ny, t_term;
  bit t_bad;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; mx = 0; my = 0; msx = 0; msy = 0;
    mminx = 63; mmaxx = 0; mminy = 63; mmaxy = 0;
    mstep = 0; meven = 0; modd = 0; marea = 0;
    mclosed = 0; mrv = 0; merr = 0;
  endtask

  task automatic model_edge();
    if (bus.start_valid) begin
      m_state = 1;
      mx = int'(bus.start_x); my = int'(bus.start_y);
      msx = mx; msy = my;
      mminx = mx; mmaxx = mx; mminy = my; mmaxy = my;
      mstep = 0; meven = 0; modd = 0; marea = 0;
      mclosed = 0; mrv = 0; merr = 0;
    end else if (m_state == 1) begin
      t_bad = 1'b0;
      if (bus.code_valid) begin
        t_dx = dxt[bus.code_in];
        t_dy = dyt[bus.code_in];
        t_term = mx * t_dy - my * t_dx;
        t_nx = mx + t_dx;
        t_ny = my + t_dy;
        if (t_nx < 0 || t_nx > 63 || t_ny < 0 || t_ny > 63 || mstep == 255 ||
            marea + t_term > 16383 || marea + t_term < -16384) begin
          t_bad = 1'b1;
          m_state = 3; merr = 1; mrv = 0;
        end else begin
          mx = t_nx; my = t_ny;
          if (mx < mminx) mminx = mx;
          if (mx > mmaxx) mmaxx = mx;
          if (my < mminy) mminy = my;
          if (my > mmaxy) mmaxy = my;
          mstep++;
          if (bus.code_in % 2 == 0) meven++; else modd++;
          marea += t_term;
        end
      end
      if (!t_bad && bus.chain_end) begin
        m_state = 2;
        mclosed = (mx == msx && my == msy) ? 1 : 0;
        mrv = mclosed;
        merr = 1 - mclosed;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_edge();
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("busy", int'(bus.busy), (m_state == 1) ? 1 : 0);
        check("result_valid", int'(bus.result_valid), mrv);
        check("error", int'(bus.error), merr);
        if (m_state != 3) begin
          check("min_x", int'(bus.min_x), mminx);
          check("max_x", int'(bus.max_x), mmaxx);
          check("min_y", int'(bus.min_y), mminy);
          check("max_y", int'(bus.max_y), mmaxy);
          check("step_count", int'(bus.step_count), mstep);
          check("even_count", int'(bus.even_count), meven);
          check("odd_count", int'(bus.odd_count), modd);
          check("area2", int'($signed(bus.area2)), marea);
          check("closed", int'(bus.closed), mclosed);
        end
      end
    end
  end

  task automatic drive(input bit sv, input int sx, input int sy,
                       input bit cv, input int c, input bit ce);
    @(posedge clk);
    #1;
    bus.start_valid = sv;
    bus.start_x     = sx[5:0];
    bus.start_y     = sy[5:0];
    bus.code_valid  = cv;
    bus.code_in     = c[2:0];
    bus.chain_end   = ce;
  endtask

  task automatic idle();             drive(0, 0, 0, 0, 0, 0); endtask
  task automatic start(input int x, input int y); drive(1, x, y, 0, 0, 0); endtask
  task automatic code(input int c);  drive(0, 0, 0, 1, c, 0); endtask
  task automatic endc();             drive(0, 0, 0, 0, 0, 1); endtask

  initial begin
    int sx, sy, len;
    bus.start_valid = 0; bus.start_x = 0; bus.start_y = 0;
    bus.code_valid = 0; bus.code_in = 0; bus.chain_end = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("reset_min_x", int'(bus.min_x), 63);
    check("reset_step", int'(bus.step_count), 0);

    // Unit axial square.
    start(10, 10); code(0); code(6); code(4); code(2); endc(); idle();
    check("t1_min_x", int'(bus.min_x), 10);
    check("t1_max_x", int'(bus.max_x), 11);
    check("t1_max_y", int'(bus.max_y), 11);
    check("t1_even", int'(bus.even_count), 4);
    check("t1_area2", int'($signed(bus.area2)), 2);
    check("t1_closed", int'(bus.closed), 1);
    check("t1_rv", int'(bus.result_valid), 1);

    // Codes in DONE are ignored; a new start clears the results.
    code(0); idle();
    check("t6_step_held", int'(bus.step_count), 4);
    check("t6_area_held", int'($signed(bus.area2)), 2);
    start(3, 3); idle();
    check("t6_rv_clear", int'(bus.result_valid), 0);
    check("t6_busy", int'(bus.busy), 1);

    // Diagonal diamond.
    start(20, 20); code(7); code(5); code(3); code(1); endc(); idle();
    check("t2_min_x", int'(bus.min_x), 19);
    check("t2_max_y", int'(bus.max_y), 22);
    check("t2_odd", int'(bus.odd_count), 4);
    check("t2_area2", int'($signed(bus.area2)), 4);
    check("t2_closed", int'(bus.closed), 1);

    // Open chain.
    start(5, 5); code(0); code(0); endc(); idle();
    check("t3_closed", int'(bus.closed), 0);
    check("t3_error", int'(bus.error), 1);
    check("t3_rv", int'(bus.result_valid), 0);
    check("t3_max_x", int'(bus.max_x), 7);

    // Step off the left edge, then recover with a new start.
    start(0, 30); code(4); idle();
    check("t4_error", int'(bus.error), 1);
    check("t4_busy", int'(bus.busy), 0);
    start(1, 1); idle();
    check("t4_err_clear", int'(bus.error), 0);
    check("t4_busy2", int'(bus.busy), 1);

    // Step counter saturation: the 256th code is a fault.
    start(30, 30);
    for (int i = 0; i < 255; i++) code((i % 2 == 0) ? 0 : 4);
    idle();
    check("sat_step", int'(bus.step_count), 255);
    check("sat_no_err", int'(bus.error), 0);
    code(0); idle();
    check("sat_error", int'(bus.error), 1);

    // Asynchronous reset in the middle of a trace.
    start(10, 10); code(0); code(6);
    #2 reset_n = 1'b0;
    #1;
    check("t5_busy", int'(bus.busy), 0);
    check("t5_min_x", int'(bus.min_x), 63);
    check("t5_min_y", int'(bus.min_y), 63);
    check("t5_step", int'(bus.step_count), 0);
    check("t5_max_x", int'(bus.max_x), 0);
    @(posedge clk);
    #1;
    bus.code_valid = 0; bus.start_valid = 0; bus.chain_end = 0;
    reset_n = 1'b1;

    // Random chains, strobe collisions and restarts.
    for (int n = 0; n < 60; n++) begin
      sx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(12, 51);
      sy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(12, 51);
      drive(1, sx, sy, $urandom_range(0, 1), $urandom_range(0, 7), 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        if ($urandom_range(0, 24) == 0)
          drive(1, $urandom_range(8, 55), $urandom_range(8, 55), 1, $urandom_range(0, 7), 0);
        if (i == len - 1 && $urandom_range(0, 1) == 1)
          drive(0, 0, 0, 1, $urandom_range(0, 7), 1);
        else
          code($urandom_range(0, 7));
      end
      endc();
      drive(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
      idle();
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
